// File: rtl/reg_arbiter_pkg.sv
// rtl/reg_arbiter_pkg.sv - shared types, defaults and helpers for the register-bank write arbiter
package reg_arbiter_pkg;

  localparam int NREQ_DEF = 3;
  localparam int NREG_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int MAX_NREG = 16;
  localparam int MAX_AW   = 4;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  function automatic logic [MAX_NREG-1:0] onehot(input logic [MAX_AW-1:0] idx);
    logic [MAX_NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_arbiter_if.sv
// rtl/reg_arbiter_if.sv - requester/register-bank bus; lock vector present with REG_ARBITER_LOCK_EN
interface reg_arbiter_if
  import reg_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int W    = W_DEF
);
  localparam int AW = $clog2(NREG);

  logic                 clr;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*W-1:0]    wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREG-1:0]      reg_we;
  logic [W-1:0]         reg_d;
  logic                 busy;
`ifdef REG_ARBITER_LOCK_EN
  logic [NREQ-1:0]      lock;

  modport master (output clr, req, addr, wdata, lock, input gnt, reg_we, reg_d, busy);
  modport slave  (input clr, req, addr, wdata, lock, output gnt, reg_we, reg_d, busy);
`else
  modport master (output clr, req, addr, wdata, input gnt, reg_we, reg_d, busy);
  modport slave  (input clr, req, addr, wdata, output gnt, reg_we, reg_d, busy);
`endif

endinterface

// File: rtl/reg_arbiter_rr_pick.sv
// rtl/reg_arbiter_rr_pick.sv - combinational round-robin selector: first request at or after ptr
module rr_pick
  import reg_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [PW-1:0]   idx_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  // Candidate index wraps at NREQ, which need not be a power of two.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      cand = sum[PW-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// rtl/reg_arbiter.sv - round-robin write-port controller with clear sequence; REG_ARBITER_LOCK_EN adds grant locking
module reg_arbiter
  import reg_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int W    = W_DEF
) (
  input logic         clk,
  input logic         rst,
  reg_arbiter_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int PW = $clog2(NREQ);

  state_e          state_q;
  logic [AW-1:0]   cidx_q;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREG-1:0] reg_we_q;
  logic [W-1:0]    reg_d_q;
  logic            busy_q;

  logic            locked;
  logic [NREQ-1:0] arb_req;
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   ptr_d;
  logic [NREQ-1:0] gnt_d;
  logic [AW-1:0]   sel_addr;
  logic [W-1:0]    sel_data;

`ifdef REG_ARBITER_LOCK_EN
  assign locked = |(gnt_q & bus.lock);
`else
  assign locked = 1'b0;
`endif

  // A requester in its grant cycle is masked, unless it holds the lock.
  assign arb_req = locked ? (bus.req & gnt_q) : (bus.req & ~gnt_q);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (arb_req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    gnt_d    = '0;
    gnt_d[pick_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == PW'(i)) begin
        sel_addr = bus.addr[i*AW +: AW];
        sel_data = bus.wdata[i*W +: W];
      end
    end
    ptr_d = ptr_q;
    if (!locked) ptr_d = (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
  end

  // busy_q lags the state by one cycle and also gates the first arbitration after a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_CLEAR;
      cidx_q   <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      reg_we_q <= '0;
      reg_d_q  <= '0;
      busy_q   <= 1'b1;
    end else begin
      gnt_q    <= '0;
      reg_we_q <= '0;
      reg_d_q  <= '0;
      if (bus.clr) begin
        state_q  <= ST_CLEAR;
        reg_we_q <= NREG'(onehot('0));
        cidx_q   <= AW'(1);
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_CLEAR: begin
            busy_q   <= 1'b1;
            reg_we_q <= NREG'(onehot(MAX_AW'(cidx_q)));
            if (cidx_q == AW'(NREG-1)) begin
              state_q <= ST_RUN;
              cidx_q  <= '0;
            end else begin
              cidx_q <= cidx_q + 1'b1;
            end
          end
          ST_RUN: begin
            busy_q <= 1'b0;
            if (!busy_q && pick_valid) begin
              gnt_q    <= gnt_d;
              reg_we_q <= NREG'(onehot(MAX_AW'(sel_addr)));
              reg_d_q  <= sel_data;
              ptr_q    <= ptr_d;
            end
          end
          default: state_q <= ST_CLEAR;
        endcase
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.reg_we = reg_we_q;
  assign bus.reg_d  = reg_d_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// tb/tb_reg_arbiter.sv - scoreboard bench for reg_arbiter (NREQ=3, NREG=4, W=8)
module tb_reg_arbiter;

  logic clk;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  typedef struct {
    logic [2:0] gnt;
    logic [3:0] we;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  reg_arbiter_if #(.NREQ(3), .NREG(4), .W(8)) bus ();

  reg_arbiter #(.NREQ(3), .NREG(4), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
    bus.req[i]           = 1'b1;
    bus.addr[i*2 +: 2]   = a;
    bus.wdata[i*8 +: 8]  = d;
  endtask

  task automatic drop_req(input int i);
    bus.req[i] = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] g, input logic [3:0] w, input logic [7:0] d);
    exp_t x;
    x.gnt = g;
    x.we  = w;
    x.d   = d;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    logic [3:0] exp_we;
    bus.clr = 1'b0; bus.req = '0; bus.addr = '0; bus.wdata = '0;
`ifdef REG_ARBITER_LOCK_EN
    bus.lock = '0;
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.gnt, bus.reg_we, bus.reg_d, bus.busy} !== {3'b000, 4'b0000, 8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: gnt=%b we=%b d=%h busy=%b, expected 000 0000 00 1",
               bus.gnt, bus.reg_we, bus.reg_d, bus.busy);
    end
    set_req(0, 2'd3, 8'hFF);
    push_exp(3'b001, 4'b1000, 8'hFF);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) begin
        exp_we = 4'b0001 << c;
        tests_run++;
        if (bus.reg_we !== exp_we || bus.reg_d !== 8'h00 || bus.busy !== 1'b1 || bus.gnt !== 3'b000) begin
          tests_failed++;
          $display("FAIL clear_step%0d: we=%b d=%h busy=%b gnt=%b, expected we=%b d=00 busy=1 gnt=000",
                   c, bus.reg_we, bus.reg_d, bus.busy, bus.gnt, exp_we);
        end
      end else if (c == 4) begin
        tests_run++;
        if (bus.busy !== 1'b0 || bus.gnt !== 3'b000 || bus.reg_we !== 4'b0000) begin
          tests_failed++;
          $display("FAIL busy_fall: busy=%b gnt=%b we=%b, expected busy=0 gnt=000 we=0000",
                   bus.busy, bus.gnt, bus.reg_we);
        end
      end else begin
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL first_grant: scoreboard empty, got gnt=%b", bus.gnt);
        end else begin
          e = exp_q.pop_front();
          tests_run++;
          if (bus.gnt !== e.gnt || bus.reg_we !== e.we || bus.reg_d !== e.d) begin
            tests_failed++;
            $display("FAIL first_grant: got gnt=%b we=%b d=%h, expected gnt=%b we=%b d=%h",
                     bus.gnt, bus.reg_we, bus.reg_d, e.gnt, e.we, e.d);
          end
        end
        drop_req(0);
      end
    end
  endtask

  task automatic test_single();
    set_req(1, 2'd2, 8'hA5);
    push_exp(3'b010, 4'b0100, 8'hA5);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL single: scoreboard empty, got gnt=%b", bus.gnt);
    end else begin
      e = exp_q.pop_front();
      tests_run++;
      if (bus.gnt !== e.gnt || bus.reg_we !== e.we || bus.reg_d !== e.d) begin
        tests_failed++;
        $display("FAIL single: got gnt=%b we=%b d=%h, expected gnt=%b we=%b d=%h",
                 bus.gnt, bus.reg_we, bus.reg_d, e.gnt, e.we, e.d);
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus.gnt !== 3'b000 || bus.reg_we !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_mask: gnt=%b we=%b, expected gnt=000 we=0000", bus.gnt, bus.reg_we);
    end
    drop_req(1);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    set_req(0, 2'd1, 8'h11);
    set_req(1, 2'd3, 8'h22);
    push_exp(3'b001, 4'b0010, 8'h11);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.gnt !== 3'b000) begin
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL wrap: unexpected grant gnt=%b", bus.gnt);
        end else begin
          e = exp_q.pop_front();
          tests_run++;
          if (bus.gnt !== e.gnt || bus.reg_we !== e.we || bus.reg_d !== e.d) begin
            tests_failed++;
            $display("FAIL wrap: got gnt=%b we=%b d=%h, expected gnt=%b we=%b d=%h",
                     bus.gnt, bus.reg_we, bus.reg_d, e.gnt, e.we, e.d);
          end
        end
        for (int i = 0; i < 3; i++) if (bus.gnt[i]) drop_req(i);
      end
      if (c == 0) begin
        set_req(2, 2'd0, 8'h44);
        push_exp(3'b010, 4'b1000, 8'h22);
        push_exp(3'b100, 4'b0001, 8'h44);
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL wrap_pending: %0d grants missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_fairness();
    int n = 0;
    for (int i = 0; i < 3; i++) set_req(i, 2'(i), 8'hC0 + 8'(i));
    for (int k = 0; k < 6; k++) push_exp(3'b001 << (k % 3), 4'b0001 << (k % 3), 8'hC0 + 8'(k % 3));
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 6) begin
        tests_run++;
        if (bus.gnt === 3'b000) begin
          tests_failed++;
          $display("FAIL fairness_gap: cycle %0d gnt=%b, expected a grant", c, bus.gnt);
        end
      end
      if (bus.gnt !== 3'b000) begin
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL fairness: unexpected grant gnt=%b", bus.gnt);
        end else begin
          e = exp_q.pop_front();
          tests_run++;
          if (bus.gnt !== e.gnt || bus.reg_we !== e.we || bus.reg_d !== e.d) begin
            tests_failed++;
            $display("FAIL fairness: got gnt=%b we=%b d=%h, expected gnt=%b we=%b d=%h",
                     bus.gnt, bus.reg_we, bus.reg_d, e.gnt, e.we, e.d);
          end
        end
        n++;
        if (n == 6) bus.req = '0;
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL fairness_pending: %0d grants missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    set_req(0, 2'd1, 8'h90);
    for (int k = 0; k < 3; k++) push_exp(3'b001, 4'b0010, 8'h90 + 8'(k));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.gnt !== 3'b000) begin
        tests_run++;
        if (c != 2 * n) begin
          tests_failed++;
          $display("FAIL b2b_timing: grant %0d at cycle %0d, expected cycle %0d", n, c, 2 * n);
        end
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL b2b: unexpected grant gnt=%b", bus.gnt);
        end else begin
          e = exp_q.pop_front();
          tests_run++;
          if (bus.gnt !== e.gnt || bus.reg_we !== e.we || bus.reg_d !== e.d) begin
            tests_failed++;
            $display("FAIL b2b: got gnt=%b we=%b d=%h, expected gnt=%b we=%b d=%h",
                     bus.gnt, bus.reg_we, bus.reg_d, e.gnt, e.we, e.d);
          end
        end
        n++;
        bus.wdata[7:0] = 8'h90 + 8'(n);
        if (n == 3) drop_req(0);
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_pending: %0d grants missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clear_mid();
    logic [3:0] exp_we;
    set_req(1, 2'd2, 8'h55);
    set_req(2, 2'd1, 8'h66);
    push_exp(3'b010, 4'b0100, 8'h55);
    push_exp(3'b100, 4'b0010, 8'h66);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (bus.gnt !== 3'b000) begin
        tests_run++;
        if (!((bus.gnt === 3'b010 && c == 0) || (bus.gnt === 3'b100 && c == 6))) begin
          tests_failed++;
          $display("FAIL clr_grant_time: gnt=%b at cycle %0d, expected 010@0 or 100@6", bus.gnt, c);
        end
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL clr_mid: unexpected grant gnt=%b", bus.gnt);
        end else begin
          e = exp_q.pop_front();
          tests_run++;
          if (bus.gnt !== e.gnt || bus.reg_we !== e.we || bus.reg_d !== e.d) begin
            tests_failed++;
            $display("FAIL clr_mid: got gnt=%b we=%b d=%h, expected gnt=%b we=%b d=%h",
                     bus.gnt, bus.reg_we, bus.reg_d, e.gnt, e.we, e.d);
          end
        end
        for (int i = 0; i < 3; i++) if (bus.gnt[i]) drop_req(i);
      end
      if (c >= 1 && c <= 4) begin
        exp_we = 4'b0001 << (c - 1);
        tests_run++;
        if (bus.reg_we !== exp_we || bus.reg_d !== 8'h00 || bus.busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL clr_seq%0d: we=%b d=%h busy=%b, expected we=%b d=00 busy=1",
                   c, bus.reg_we, bus.reg_d, bus.busy, exp_we);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (bus.busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL clr_end: busy=%b, expected 0", bus.busy);
        end
      end
      bus.clr = (c == 0);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL clr_pending: %0d grants missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

`ifdef REG_ARBITER_LOCK_EN
  task automatic test_lock();
    int n = 0;
    bus.lock[0] = 1'b1;
    set_req(0, 2'd0, 8'h70);
    set_req(1, 2'd3, 8'h81);
    for (int k = 0; k < 3; k++) push_exp(3'b001, 4'b0001, 8'h70 + 8'(k));
    push_exp(3'b010, 4'b1000, 8'h81);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (bus.gnt !== 3'b000) begin
        tests_run++;
        if (c != n) begin
          tests_failed++;
          $display("FAIL lock_timing: grant %0d at cycle %0d, expected cycle %0d", n, c, n);
        end
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL lock: unexpected grant gnt=%b", bus.gnt);
        end else begin
          e = exp_q.pop_front();
          tests_run++;
          if (bus.gnt !== e.gnt || bus.reg_we !== e.we || bus.reg_d !== e.d) begin
            tests_failed++;
            $display("FAIL lock: got gnt=%b we=%b d=%h, expected gnt=%b we=%b d=%h",
                     bus.gnt, bus.reg_we, bus.reg_d, e.gnt, e.we, e.d);
          end
        end
        n++;
        if (bus.gnt[0]) begin
          bus.wdata[7:0] = 8'h70 + 8'(n);
          if (n == 3) begin
            bus.lock[0] = 1'b0;
            drop_req(0);
          end
        end
        if (bus.gnt[1]) drop_req(1);
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL lock_pending: %0d grants missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask
`endif

  task automatic test_async_reset();
    set_req(2, 2'd3, 8'hEE);
    @(negedge clk);
    tests_run++;
    if (bus.gnt !== 3'b100 || bus.reg_we !== 4'b1000 || bus.reg_d !== 8'hEE) begin
      tests_failed++;
      $display("FAIL arst_pre: gnt=%b we=%b d=%h, expected gnt=100 we=1000 d=ee",
               bus.gnt, bus.reg_we, bus.reg_d);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (bus.gnt !== 3'b000 || bus.reg_we !== 4'b0000 || bus.reg_d !== 8'h00 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_abort: gnt=%b we=%b d=%h busy=%b, expected 000 0000 00 1",
               bus.gnt, bus.reg_we, bus.reg_d, bus.busy);
    end
    drop_req(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_back_to_back();
    test_clear_mid();
`ifdef REG_ARBITER_LOCK_EN
    test_lock();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_arbiter.md
# reg_arbiter

Write-port controller for the CPU's 8-bit register bank. It shares one write path between several requesters (ALU result, memory load, immediate load) using round-robin arbitration with a req/gnt handshake. It drives the per-register write enables and the common data bus of the enable-gated register instances. It also runs a clear sequence that zeroes every register after reset or on command.

## Interface
- `NREQ`, default 3: number of requesters (2..8).
- `NREG`, default 4: number of registers in the bank (power of two, 2..16).
- `W`, default 8: data width.
- `AW`, derived as `$clog2(NREG)`: register address width.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `clr`  in  1  synchronous request to re-run the clear sequence.
- `req`  in  NREQ  per-requester write request.
- `addr`  in  NREQ*AW  target register per requester; requester i uses slice [i*AW +: AW].
- `wdata`  in  NREQ*W  write data per requester; requester i uses slice [i*W +: W].
- `gnt`  out  NREQ  one-hot grant pulse; at most one bit high per cycle.
- `reg_we`  out  NREG  one-hot write enable to the register bank.
- `reg_d`  out  W  write data to the register bank.
- `busy`  out  1  high while the clear sequence runs.

## Operation
FSM with two states, CLEAR and RUN.

- **CLEAR**
  - Counter `cidx` steps 0..NREG-1, one register per cycle.
  - Each cycle: `reg_we` = onehot(`cidx`), `reg_d` = 0, `busy` = 1.
  - `req` is ignored and `gnt` stays 0.
  - After `cidx` = NREG-1 the FSM moves to RUN and `cidx` returns to 0.
- **RUN**
  - Each cycle the arbiter picks the first asserted `req` at or after pointer `ptr`, wrapping modulo NREQ.
  - The winner's index, address and data are registered.
  - In the following cycle the block drives `gnt[winner]` = 1, `reg_we` = onehot(addr), `reg_d` = wdata.
  - `ptr` is updated to winner+1 (mod NREQ).
  - If no request is pending, `gnt`, `reg_we` and `reg_d` are all 0.
- **Handshake**
  - A requester holds `req`, `addr` and `wdata` stable until it sees its `gnt` high.
  - `gnt` is a single-cycle pulse. The register captures `reg_d` on the edge that ends the `gnt` cycle.
  - During the cycle a requester's `gnt` is high, its `req` is masked from arbitration. A still-high `req` in that cycle is not a second request, and the requester may drop `req` in that same cycle.
- **Clear command**
  - `clr` = 1 in RUN: the grant already registered for that cycle still completes.
  - From the next cycle the FSM is in CLEAR. Any arbitration result from the `clr` cycle is discarded, so no grant is issued for it.
  - `clr` during CLEAR restarts `cidx` at 0.
- **Arithmetic**
  - `ptr` and the winner index are `$clog2(NREQ)` bits and wrap explicitly at NREQ, not at a power of two.
  - `addr` values ≥ NREG cannot occur, because NREG is a power of two.

## Timing
- Reset (`rst` = 0) asynchronously forces:
  - state = CLEAR, `cidx` = 0, `ptr` = 0;
  - `gnt` = 0, `reg_we` = 0, `reg_d` = 0, `busy` = 1.
  - Reset asserted mid-grant or mid-clear aborts immediately.
- After `rst` deasserts, the clear sequence takes NREG cycles. `busy` falls in cycle NREG, so first `req` sampling happens in that cycle.
- Latency from `req` sampled (no contention) to `gnt`/`reg_we`: 1 cycle. Register content updates at the edge after that.
- Throughput: one write per cycle when different requesters alternate. A single requester can complete at most one write every 2 cycles, because of the grant-cycle mask.
- Worst-case wait with all requesters active: NREQ grant slots.

## Configuration
- Macro `REG_ARBITER_LOCK_EN`.
- **Defined:**
  - Adds input `lock` (NREQ bits).
  - While the currently granted requester holds its `lock` bit high, `ptr` is not advanced and all other requesters are masked.
  - The grant-cycle mask is waived for the locked requester, so back-to-back grants to it (one per cycle) are allowed.
  - The lock ends the first cycle its `lock` bit is low.
  - `clr` or reset breaks a lock.
- **Not defined:** the `lock` port is absent and arbitration is plain round-robin as above.

## Structure
- Shared package `reg_arbiter_pkg`:
  - state enum (CLEAR, RUN);
  - helper function `onehot` (index to one-hot vector);
  - default parameter constants.
- One sub-module, `rr_pick`: a combinational round-robin selector taking a request vector and `ptr`, returning a valid flag and the winner index. It is instanced once.
- The FSM, counters and output registers stay in `reg_arbiter`.

## Test plan
- **Reset and clear:** NREG=4, release `rst` → `reg_we` = 0001, 0010, 0100, 1000 on cycles 0–3 with `reg_d` = 0 and `busy` = 1; `busy` = 0 in cycle 4.
- **Single request:** `req[1]` = 1 with `addr` = 2 and `wdata` = 0xA5 → `gnt` = 010, `reg_we` = 0100, `reg_d` = 0xA5 one cycle later; no second grant while `req[1]` is still held in the `gnt` cycle.
- **Fairness:** all three `req` held continuously from `ptr` = 0 → grant order 0, 1, 2, 0, 1, 2, one grant per cycle.
- **Wrap:** `ptr` = 2 with `req` = 011 → requester 0 is granted, then `ptr` = 1.
- **Clear mid-stream:** `clr` pulsed while requester 2 is pending → the registered grant completes, then 4 clear cycles follow, then requester 2 is granted.
- **Lock (`REG_ARBITER_LOCK_EN`):** requester 0 locked for 3 writes while `req[1]` is held → `gnt[0]` on 3 consecutive cycles, then `gnt[1]`.
